nios_pio_sched: RTL and testbench
=================================

Name: nios_pio_sched

Overview:
- Avalon-MM write master that shares the 32-bit output PIO between NUM_REQ hardware requesters.
- Each request is one register operation: write, set-bits or clear-bits. Requests are granted round-robin and issued as single-cycle writes to PIO offsets 0, 4 or 5.
- Keeps a shadow copy of the PIO output value, so requesters never read the slave back.
- Sits between fabric-side requesters and the PIO s1 slave, in place of the CPU data master on that port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 0, idle cycles forced after each issued write (0..15).
- DATA_W, 32, PIO data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_op  in  2*NUM_REQ  operation code; requester i uses bits [2i+1:2i].
- req_data  in  DATA_W*NUM_REQ  operand; requester i uses slice i.
- req_ready  out  NUM_REQ  accept strobe; handshake completes when valid&&ready.
- avm_address  out  3  PIO register offset.
- avm_chipselect  out  1  slave select.
- avm_write_n  out  1  active-low write.
- avm_writedata  out  DATA_W  write data.
- shadow  out  DATA_W  mirrored PIO output value.
- busy  out  1  high in any state other than IDLE.
- err_op  out  1  one-cycle pulse when a reserved op is accepted.

Behaviour:
- Opcodes:
  - 00 WRITE: address 0, data = operand.
  - 01 SET: address 4, PIO ORs in the operand.
  - 10 CLR: address 5, PIO clears the operand bits.
  - 11 reserved.
- Reset values: avm_chipselect 0, avm_write_n 1, avm_address 0, avm_writedata 0, shadow 0 (same as PIO reset value), busy 0, err_op 0, req_ready 0, rr pointer 0, state IDLE.
- All avm_* outputs, shadow, busy and err_op are registered. req_ready is combinational from state and arbiter grant.
- States: IDLE, ISSUE, GAP.
- IDLE:
  - No req_valid bit set -> stay in IDLE.
  - Otherwise grant the first valid requester searching from the rr pointer upward, modulo NUM_REQ.
  - req_ready is one-hot on the granted requester for that one cycle.
  - Latch op and data; pointer <= grant+1 (wraps NUM_REQ-1 -> 0). Next state ISSUE.
- ISSUE (exactly 1 cycle):
  - Valid op: chipselect=1, write_n=0, address and data per opcode.
  - Shadow update at end of cycle: WRITE -> d; SET -> shadow|d; CLR -> shadow&~d.
  - Reserved op: no bus write (chipselect 0), err_op=1, shadow unchanged.
  - Next state: GAP if GAP_CYCLES>0, else IDLE.
- GAP: bus idle, counter runs GAP_CYCLES cycles, then IDLE.
- Latency:
  - Accept at cycle T; write strobe at T+1; new shadow visible at T+2.
  - With GAP_CYCLES=0 the next accept is at T+2 at the earliest, so throughput is one op per 2 cycles.
- Requester rules:
  - req_valid/op/data must stay stable until ready. A request dropped before ready is never issued.
  - A requester that keeps valid asserted gets at most one grant per round while others are pending.
- Simultaneous requests: strict rotation from the pointer, so no starvation. After reset requester 0 wins first.
- Reset mid-operation:
  - Reset dominates in any state; next cycle is IDLE with reset values.
  - An in-flight ISSUE strobe already on the bus completes in that cycle; shadow is then cleared.
  - The system resets this block and the PIO together, so shadow stays consistent.
- The PIO must have no other writer while this block owns it.

Decomposition:
- Package nios_pio_sched_pkg holds:
  - opcode constants OP_WRITE/OP_SET/OP_CLR/OP_RSVD;
  - PIO offsets PIO_DATA=0, PIO_SET=4, PIO_CLR=5;
  - state encoding IDLE/ISSUE/GAP.
- One sub-module, nios_rr_arbiter:
  - parameter NUM_REQ; inputs req vector and pointer; output one-hot grant and its index (combinational).
- FSM, gap counter and shadow logic stay in the top module.

Test Plan:
- Reset, then requester 2 issues WRITE 0x0000_00FF -> ready[2] at T; at T+1 address 0, chipselect 1, write_n 0, data 0xFF; shadow=0x0000_00FF at T+2.
- From shadow 0xFF: SET 0xF000_0000 then CLR 0x0000_000F, both from requester 0 -> writes at address 4 then address 5; shadow ends at 0xF000_00F0, matching the PIO out_port.
- All four requesters valid continuously after reset -> grant order 0,1,2,3,0,1; one write every 2 cycles with GAP_CYCLES=0.
- GAP_CYCLES=3 with two requesters pending -> strobes 5 cycles apart; busy stays high between them.
- Requester 1 issues op 11 with data 0x1234 -> ready[1] pulses, err_op=1 at T+1, no write strobe, shadow unchanged, pointer advances to 2.
- Reset asserted during GAP after WRITE 0xAAAA_5555 -> next cycle IDLE, shadow 0, write_n 1; a pending request is re-granted starting from requester 0.

Source files
------------

// File: rtl/nios_pio_sched_pkg.sv
// Shared constants for the PIO write scheduler:
// opcodes, PIO register offsets and FSM states.
package nios_pio_sched_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [2:0] PIO_DATA = 3'd0;
  localparam logic [2:0] PIO_SET  = 3'd4;
  localparam logic [2:0] PIO_CLR  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic logic [2:0] op_addr(
    input logic [1:0] op
  );
    case (op)
      OP_SET:  return PIO_SET;
      OP_CLR:  return PIO_CLR;
      default: return PIO_DATA;
    endcase
  endfunction

endpackage

// File: rtl/nios_pio_sched_if.sv
// Requester handshake plus Avalon-MM write
// master signals toward the PIO s1 slave.
interface nios_pio_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [2*NUM_REQ-1:0]      req_op;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2:0]                avm_address;
  logic                      avm_chipselect;
  logic                      avm_write_n;
  logic [DATA_W-1:0]         avm_writedata;

  modport master (
    input  req_valid,
    input  req_op,
    input  req_data,
    output req_ready,
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata
  );

  modport slave (
    output req_valid,
    output req_op,
    output req_data,
    input  req_ready,
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata
  );
endinterface

// File: rtl/nios_rr_arbiter.sv
// Combinational round-robin arbiter: first set
// request at or above the pointer, wrapping.
module nios_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  int c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/nios_pio_sched.sv
// Round-robin scheduler sharing one output PIO
// between hardware requesters; keeps a shadow.
module nios_pio_sched
  import nios_pio_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  nios_pio_sched_if.master  bus,
  output logic [DATA_W-1:0] shadow,
  output logic              busy,
  output logic              err_op
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [3:0] GAP_LD =
    4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  state_e state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              cs_q, cs_d;
  logic              wn_q, wn_d;
  logic [2:0]        addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] gnt, rdy;
  logic [IW-1:0]      gidx;
  logic               gany;
  logic [1:0]         g_op;
  logic [DATA_W-1:0]  g_data;

  nios_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  assign g_op   = bus.req_op[2*int'(gidx) +: 2];
  assign g_data = bus.req_data[DATA_W*int'(gidx) +: DATA_W];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    op_d     = op_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    cs_d     = 1'b0;
    wn_d     = 1'b1;
    addr_d   = addr_q;
    wd_d     = wd_q;
    shadow_d = shadow_q;
    err_d    = 1'b0;
    rdy      = '0;
    unique case (state_q)
      IDLE: begin
        if (gany) begin
          rdy     = gnt;
          state_d = ISSUE;
          ptr_d   = (gidx == IW'(NUM_REQ - 1))
                    ? '0 : gidx + 1'b1;
          op_d    = g_op;
          data_d  = g_data;
          if (g_op == OP_RSVD) begin
            err_d = 1'b1;
          end else begin
            cs_d   = 1'b1;
            wn_d   = 1'b0;
            addr_d = op_addr(g_op);
            wd_d   = g_data;
          end
        end
      end
      ISSUE: begin
        unique case (op_q)
          OP_WRITE: shadow_d = data_q;
          OP_SET:   shadow_d = shadow_q | data_q;
          OP_CLR:   shadow_d = shadow_q & ~data_q;
          OP_RSVD:  shadow_d = shadow_q;
        endcase
        state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        cnt_d   = GAP_LD;
      end
      GAP: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      op_q     <= OP_WRITE;
      data_q   <= '0;
      cnt_q    <= '0;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      addr_q   <= PIO_DATA;
      wd_q     <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      op_q     <= op_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      wn_q     <= wn_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // no grant is visible while reset is held
  assign bus.req_ready      = rdy & {NUM_REQ{~reset}};
  assign bus.avm_address    = addr_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write_n    = wn_q;
  assign bus.avm_writedata  = wd_q;
  assign shadow = shadow_q;
  assign busy   = busy_q;
  assign err_op = err_q;

endmodule

// File: tb/tb_nios_pio_sched.sv
// Bench for nios_pio_sched: GAP=0 and GAP=3
// instances checked against a transaction model.
module tb_nios_pio_sched;
  import nios_pio_sched_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic [N-1:0] sv [2];
  logic [1:0]   so [2][N];
  logic [31:0]  sd [2][N];

  nios_pio_sched_if #(.NUM_REQ(N), .DATA_W(32)) b0 ();
  nios_pio_sched_if #(.NUM_REQ(N), .DATA_W(32)) b1 ();

  logic [31:0] sh0, sh1;
  logic bz0, bz1, er0, er1;

  nios_pio_sched #(.NUM_REQ(N), .GAP_CYCLES(0), .DATA_W(32)) dut0 (
    .clk(clk), .reset(rst0), .bus(b0.master),
    .shadow(sh0), .busy(bz0), .err_op(er0)
  );

  nios_pio_sched #(.NUM_REQ(N), .GAP_CYCLES(3), .DATA_W(32)) dut1 (
    .clk(clk), .reset(rst1), .bus(b1.master),
    .shadow(sh1), .busy(bz1), .err_op(er1)
  );

  always_comb begin
    b0.req_valid = sv[0];
    b1.req_valid = sv[1];
    b0.req_op    = '0;
    b1.req_op    = '0;
    b0.req_data  = '0;
    b1.req_data  = '0;
    for (int i = 0; i < N; i++) begin
      b0.req_op[2*i +: 2]    = so[0][i];
      b1.req_op[2*i +: 2]    = so[1][i];
      b0.req_data[32*i +: 32] = sd[0][i];
      b1.req_data[32*i +: 32] = sd[1][i];
    end
  end

  // reference model state, one slot per instance
  int          ptr [2];
  int          last_g [2];
  int          free_c [2];
  int          gapc [2];
  int          granted [2];
  logic [1:0]  lop [2];
  logic [31:0] ldat [2];
  logic [31:0] msh [2];
  logic [31:0] psh [2];
  int cyc;
  int vectors;
  int miscompares;
  bit rnd;
  bit cont;
  int g0q[$], c0q[$], g1q[$], c1q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] apply_op(
    logic [31:0] s, logic [1:0] op, logic [31:0] d
  );
    case (op)
      2'd0:    return d;
      2'd1:    return s | d;
      2'd2:    return s & ~d;
      default: return s;
    endcase
  endfunction

  function automatic logic [2:0] exp_addr(logic [1:0] op);
    case (op)
      2'd1:    return 3'd4;
      2'd2:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  task automatic model_reset(int d);
    ptr[d]     = 0;
    msh[d]     = '0;
    psh[d]     = '0;
    last_g[d]  = -100;
    free_c[d]  = cyc;
    granted[d] = -1;
  endtask

  task automatic check_dut(int d);
    logic [N-1:0] rdy, er_exp;
    logic cs, wn, bz, er, rs, strobe, wr;
    logic [2:0] ad;
    logic [31:0] wd, sh;
    int g, c, oi;
    if (d == 0) begin
      rdy = b0.req_ready; cs = b0.avm_chipselect;
      wn = b0.avm_write_n; ad = b0.avm_address;
      wd = b0.avm_writedata; sh = sh0; bz = bz0;
      er = er0; rs = rst0;
    end else begin
      rdy = b1.req_ready; cs = b1.avm_chipselect;
      wn = b1.avm_write_n; ad = b1.avm_address;
      wd = b1.avm_writedata; sh = sh1; bz = bz1;
      er = er1; rs = rst1;
    end
    granted[d] = -1;
    if (rs) begin
      chk("ready_in_reset", 32'(rdy), 32'd0);
      return;
    end
    if (cyc == last_g[d] + 2) msh[d] = psh[d];
    g = -1;
    if (cyc >= free_c[d])
      for (int k = 0; k < N; k++) begin
        c = (ptr[d] + k) % N;
        if (g < 0 && sv[d][c]) g = c;
      end
    er_exp = '0;
    if (g >= 0) er_exp[g] = 1'b1;
    strobe = (cyc == last_g[d] + 1);
    wr = strobe && (lop[d] != 2'd3);
    chk("req_ready", 32'(rdy), 32'(er_exp));
    chk("chipselect", 32'(cs), 32'(wr));
    chk("write_n", 32'(wn), 32'(!wr));
    if (wr) begin
      chk("address", 32'(ad), 32'(exp_addr(lop[d])));
      chk("writedata", wd, ldat[d]);
    end
    chk("err_op", 32'(er), 32'(strobe && lop[d] == 2'd3));
    chk("busy", 32'(bz),
        32'(cyc > last_g[d] && cyc < free_c[d]));
    chk("shadow", sh, msh[d]);
    oi = -1;
    for (int i = 0; i < N; i++) if (rdy[i]) oi = i;
    if (d == 0 && oi >= 0) begin g0q.push_back(oi); c0q.push_back(cyc); end
    if (d == 1 && oi >= 0) g1q.push_back(oi);
    if (d == 1 && cs) c1q.push_back(cyc);
    if (g >= 0) begin
      last_g[d]  = cyc;
      lop[d]     = so[d][g];
      ldat[d]    = sd[d][g];
      psh[d]     = apply_op(msh[d], so[d][g], sd[d][g]);
      free_c[d]  = cyc + 2 + gapc[d];
      ptr[d]     = (g + 1) % N;
      granted[d] = g;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    #1;
    cyc++;
    if (rst0) begin rst0 = 1'b0; model_reset(0); end
    if (rst1) begin rst1 = 1'b0; model_reset(1); end
    for (int d = 0; d < 2; d++)
      if (granted[d] >= 0) begin
        if (cont) begin
          so[d][granted[d]] = 2'($urandom_range(0, 3));
          sd[d][granted[d]] = $urandom;
        end else begin
          sv[d][granted[d]] = 1'b0;
        end
      end
    if (rnd)
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N; i++)
          if (!sv[d][i] && $urandom_range(0, 2) == 0) begin
            sv[d][i] = 1'b1;
            so[d][i] = 2'($urandom_range(0, 3));
            sd[d][i] = $urandom;
          end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req(int d, int i, logic [1:0] op, logic [31:0] dat);
    sv[d][i] = 1'b1;
    so[d][i] = op;
    sd[d][i] = dat;
  endtask

  int n0, n1;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    rnd = 0; cont = 0;
    gapc[0] = 0; gapc[1] = 3;
    for (int d = 0; d < 2; d++) begin
      sv[d] = '0;
      for (int i = 0; i < N; i++) begin
        so[d][i] = 2'd0; sd[d][i] = '0;
      end
      model_reset(d);
    end

    tick();
    chk("rst_address", 32'(b0.avm_address), 32'd0);
    chk("rst_writedata", b0.avm_writedata, 32'd0);
    chk("rst_shadow", sh1, 32'd0);
    chk("rst_write_n", 32'(b1.avm_write_n), 32'd1);

    // WRITE from requester 2
    n0 = g0q.size();
    req(0, 2, OP_WRITE, 32'h0000_00FF);
    run(4);
    chk("write_grant", 32'(g0q[n0]), 32'd2);
    chk("write_shadow", sh0, 32'h0000_00FF);

    // SET then CLR from requester 0
    req(0, 0, OP_SET, 32'hF000_0000);
    run(3);
    req(0, 0, OP_CLR, 32'h0000_000F);
    run(3);
    chk("setclr_shadow", sh0, 32'hF000_00F0);

    // reserved op from requester 1, pointer moves to 2
    req(0, 1, OP_RSVD, 32'h0000_1234);
    run(3);
    chk("rsvd_shadow", sh0, 32'hF000_00F0);
    n0 = g0q.size();
    req(0, 0, OP_SET, 32'h0000_0100);
    req(0, 2, OP_CLR, 32'h0000_0010);
    run(5);
    chk("rsvd_ptr_a", 32'(g0q[n0]), 32'd2);
    chk("rsvd_ptr_b", 32'(g0q[n0+1]), 32'd0);

    // all four requesters continuously valid after reset
    rst0 = 1'b1;
    cont = 1;
    for (int i = 0; i < N; i++)
      req(0, i, 2'($urandom_range(0, 3)), $urandom);
    tick();
    n0 = g0q.size();
    run(12);
    for (int k = 0; k < 6; k++)
      chk("rr_order", 32'(g0q[n0+k]), 32'(k % 4));
    for (int k = 1; k < 6; k++)
      chk("rr_spacing", 32'(c0q[n0+k] - c0q[n0+k-1]), 32'd2);
    cont = 0;
    run(10);

    // GAP_CYCLES=3, two pending requesters
    n1 = c1q.size();
    req(1, 0, OP_WRITE, 32'h1357_9BDF);
    req(1, 2, OP_SET, 32'h0F00_0000);
    run(14);
    chk("gap_spacing", 32'(c1q[n1+1] - c1q[n1]), 32'd5);
    chk("gap_shadow", sh1, 32'h1F57_9BDF);

    // reset during GAP after WRITE from requester 1
    req(1, 1, OP_WRITE, 32'hAAAA_5555);
    tick();
    tick();
    req(1, 1, OP_SET, 32'h0000_0003);
    req(1, 3, OP_SET, 32'h0000_0030);
    rst1 = 1'b1;
    tick();
    chk("rst_gap_shadow", sh1, 32'd0);
    chk("rst_gap_write_n", 32'(b1.avm_write_n), 32'd1);
    chk("rst_gap_busy", 32'(bz1), 32'd0);
    n1 = g1q.size();
    tick();
    chk("rst_regrant", 32'(g1q[n1]), 32'd1);
    run(12);

    // randomized traffic on both instances
    rnd = 1;
    run(400);
    rnd = 0;
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
